// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
//
// Move-queue controller sitting between the SPI command decoder and the DDA
// timer/stepper path. Move commands (direction, increment,
// increment-increment, duration) are buffered in a circular queue of
// 2^BUF_ADDR entries. They are handed to the DDA one at a time, and a halt
// aborts the running move and flushes the queue.
//
// Ports:
//   CLK, reset             system clock, synchronous active-high reset
//   enable                 permits starting new moves (a running move always finishes)
//   halt                   level; abort the running move and flush while high
//   wr_valid / wr_ready    move command handshake
//   wr_dir, wr_increment, wr_incrementincrement, wr_duration
//                          move command fields
//   dda_start / dda_abort  one-cycle start / abort pulses to the DDA
//   dda_done               one-cycle end-of-move pulse from the DDA
//   dda_dir, dda_increment, dda_incrementincrement, dda_duration
//                          registered move fields presented to the DDA
//   buffer_dtr             registered "ready for more data" status
//   move_done              one-cycle pulse per completed move
//   busy, halted           state status
//   move_count             completed-move counter (wraps)
//   buf_count              queue occupancy
// ---------------------------------------------------------------------------
module move_scheduler #(
    parameter int BUF_ADDR = 2,
    parameter int INC_W    = 64,
    parameter int DUR_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic                halt,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic                wr_dir,
    input  logic [INC_W-1:0]    wr_increment,
    input  logic [INC_W-1:0]    wr_incrementincrement,
    input  logic [DUR_W-1:0]    wr_duration,
    output logic                dda_start,
    output logic                dda_abort,
    input  logic                dda_done,
    output logic                dda_dir,
    output logic [INC_W-1:0]    dda_increment,
    output logic [INC_W-1:0]    dda_incrementincrement,
    output logic [DUR_W-1:0]    dda_duration,
    output logic                buffer_dtr,
    output logic                move_done,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    move_count,
    output logic [BUF_ADDR:0]   buf_count
);

    localparam int ENTRY_W = 1 + 2 * INC_W + DUR_W;

    localparam logic [BUF_ADDR-1:0] PTR_ONE   = BUF_ADDR'(1);
    localparam logic [BUF_ADDR:0]   COUNT_ONE = (BUF_ADDR + 1)'(1);
    localparam logic [CNT_W-1:0]    MOVE_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Queue storage: one packed entry per move, no reset so it maps to RAM.
    logic [ENTRY_W-1:0] mem_reg [0:(1 << BUF_ADDR) - 1];

    logic [BUF_ADDR-1:0] wr_ptr_reg, wr_ptr_next;
    logic [BUF_ADDR-1:0] rd_ptr_reg, rd_ptr_next;
    logic [BUF_ADDR:0]   count_reg, count_next;

    logic                dda_dir_reg;
    logic [INC_W-1:0]    dda_increment_reg;
    logic [INC_W-1:0]    dda_incrementincrement_reg;
    logic [DUR_W-1:0]    dda_duration_reg;
    logic                buffer_dtr_reg;
    logic                move_done_reg;
    logic [CNT_W-1:0]    move_count_reg;

    logic push;
    logic pop;
    logic flush;
    logic load_fields;
    logic move_finished;

    // Full is simply the top bit of the occupancy count. Using only
    // registered state means a pop in the same cycle never frees a slot early.
    assign wr_ready = !count_reg[BUF_ADDR] && (state_reg != ST_HALTED);
    assign push     = wr_valid && wr_ready;

    // The head entry leaves the queue at the edge that ends the LOAD cycle.
    assign pop      = (state_reg == ST_LOAD);

    // Entering or staying in HALTED empties the queue; this overrides any
    // push/pop seen on the same edge.
    assign flush    = (state_next == ST_HALTED);

    // The DDA fields are captured on the edge entering LOAD so they are
    // already valid while dda_start is high.
    assign load_fields = (state_next == ST_LOAD);

    // Halt wins over a coincident dda_done.
    assign move_finished = (state_reg == ST_RUN) && !halt && dda_done;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (enable && (count_reg != '0)) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = halt ? ST_HALTED : ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (dda_done) begin
                    state_next = (enable && (count_reg != '0)) ? ST_LOAD : ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue pointer / occupancy next values
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + COUNT_ONE;
                2'b01:   count_next = count_reg - COUNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {wr_dir, wr_increment, wr_incrementincrement, wr_duration};
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg                  <= ST_IDLE;
            wr_ptr_reg                 <= '0;
            rd_ptr_reg                 <= '0;
            count_reg                  <= '0;
            dda_dir_reg                <= 1'b0;
            dda_increment_reg          <= '0;
            dda_incrementincrement_reg <= '0;
            dda_duration_reg           <= '0;
            buffer_dtr_reg             <= 1'b0;
            move_done_reg              <= 1'b0;
            move_count_reg             <= '0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            buffer_dtr_reg <= !count_next[BUF_ADDR] && (state_next != ST_HALTED);
            move_done_reg  <= move_finished;
            if (move_finished) begin
                move_count_reg <= move_count_reg + MOVE_ONE;
            end
            if (load_fields) begin
                {dda_dir_reg, dda_increment_reg, dda_incrementincrement_reg,
                 dda_duration_reg} <= mem_reg[rd_ptr_reg];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dda_start              = (state_reg == ST_LOAD);
    // Abort only matters while a move is being loaded or is running.
    assign dda_abort              = halt && ((state_reg == ST_LOAD) || (state_reg == ST_RUN));
    assign dda_dir                = dda_dir_reg;
    assign dda_increment          = dda_increment_reg;
    assign dda_incrementincrement = dda_incrementincrement_reg;
    assign dda_duration           = dda_duration_reg;
    assign buffer_dtr             = buffer_dtr_reg;
    assign move_done              = move_done_reg;
    assign busy                   = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
    assign halted                 = (state_reg == ST_HALTED);
    assign move_count             = move_count_reg;
    assign buf_count              = count_reg;

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Move-queue controller between the SPI command decoder and the DDA timer/stepper path.
- Buffers up to DEPTH queued move commands (direction, increment, increment-increment, duration).
- Sequences them into the DDA one at a time and reports progress via BUFFER_DTR / MOVE_DONE-style status.
- Handles HALT by aborting the running move and flushing the queue.

Parameters:
- BUF_ADDR, 2, log2 of queue depth; DEPTH = 2^BUF_ADDR.
- INC_W, 64, width of increment and increment-increment fields.
- DUR_W, 32, width of move duration (DDA ticks).
- CNT_W, 16, width of completed-move counter.

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permits starting new moves; does not stop a running move.
- halt  in  1  level; abort and flush while high.
- wr_valid  in  1  move command valid.
- wr_ready  out  1  queue can accept; = (buf_count < DEPTH) && !halted.
- wr_dir  in  1  move direction.
- wr_increment  in  INC_W  initial step increment.
- wr_incrementincrement  in  INC_W  per-tick increment delta.
- wr_duration  in  DUR_W  move length in DDA ticks.
- dda_start  out  1  one-cycle load/start pulse to the DDA.
- dda_abort  out  1  one-cycle abort pulse to the DDA.
- dda_done  in  1  one-cycle pulse from the DDA at move end.
- dda_dir, dda_increment, dda_incrementincrement, dda_duration  out  1/INC_W/INC_W/DUR_W  registered move fields.
- buffer_dtr  out  1  registered; high when buf_count < DEPTH and not halted.
- move_done  out  1  one-cycle pulse per completed move.
- busy  out  1  high in LOAD or RUN.
- halted  out  1  high in HALTED.
- move_count  out  CNT_W  count of completed moves.
- buf_count  out  BUF_ADDR+1  current queue occupancy.

Behaviour:
Reset:
- State = IDLE; queue empty; pointers and counts 0.
- All dda_* outputs 0; dda_start, dda_abort, move_done, busy, halted = 0.
- buffer_dtr = 1 on the cycle after reset releases; it is 0 while reset is high.

Queue:
- Circular buffer with registered read/write pointers; occupancy is tracked in buf_count.
- A write happens on any edge where wr_valid && wr_ready.
- A pop happens only in LOAD.
- A write and pop on the same edge leave buf_count unchanged.
- wr_ready is computed from registered state. When the queue is full, a pop on the same cycle does not admit a write.
- Pointers wrap modulo DEPTH.

State machine (registered):
- IDLE:
  - halt → HALTED.
  - Else if enable && buf_count != 0 → LOAD.
- LOAD (1 cycle):
  - Pop the head entry into the dda_* registers and assert dda_start this cycle.
  - Next state is RUN.
  - If halt is high in this cycle, halt priority applies: dda_abort is asserted and the state goes to HALTED. dda_start is still asserted; the DDA honours abort over start.
- RUN:
  - halt → HALTED with a dda_abort pulse; no move_done, move_count unchanged.
  - Else on dda_done: move_done pulse next cycle and move_count += 1, wrapping at 2^CNT_W.
  - Then → LOAD if enable && buf_count != 0, otherwise → IDLE.
  - Back-to-back moves have exactly one idle DDA cycle (the LOAD cycle) between done and the next start.
- HALTED:
  - Queue flushed on entry: pointers reset, buf_count = 0, writes rejected.
  - dda_* field registers hold their last values.
  - Stays here while halt = 1; → IDLE on the first cycle halt = 0.
- dda_done outside RUN is ignored.
- Dropping enable during RUN lets the current move finish, then goes to IDLE.

Latency:
- A write accepted at edge E0 with IDLE && enable gives buf_count = 1 after E0, state LOAD after E1, and dda_start high in the cycle after E1.
- dda_* fields are valid from the dda_start cycle and stable until the next LOAD.

Reset mid-operation:
- Same as power-on reset. No dda_abort is emitted; the DDA shares the same reset.

Test Plan:
- Single move: write {dir=1, inc=0x10, incinc=0, dur=100} in IDLE, enable=1 → dda_start one cycle, two edges after the write; fields match; dda_done → move_done one pulse, move_count=1, state IDLE, busy=0.
- Fill/full: enable=0, write 4 moves (DEPTH=4) → buf_count=4, wr_ready=0, buffer_dtr=0; a 5th write is dropped. Set enable=1 → the four moves issue in write order, with exactly one cycle from each dda_done to the next dda_start.
- Simultaneous pop and write at full: wr_valid held high during a LOAD pop → write rejected that cycle, accepted next cycle; buf_count sequence is 4,3,4.
- Halt in RUN with 2 queued → dda_abort one pulse, buf_count=0, halted=1, no move_done, move_count unchanged, writes rejected. Release halt → IDLE, a new write executes normally.
- Enable drop: enable falls during RUN with 1 queued → current move completes (move_done pulses), state IDLE, queued move held. Enable re-raised → LOAD next cycle.
- Counter wrap and spurious done: CNT_W=4, complete 16 moves → move_count=0. A dda_done pulse in IDLE → no move_done, count unchanged.
